// File: rtl/down_count_arbiter.sv
// down_count_arbiter: two-requester round-robin arbiter that owns a shared down-counter
module down_count_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] load_val0,
  input  logic [WIDTH-1:0] load_val1,
  input  logic             abort,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [WIDTH-1:0] count_out,
  output logic [1:0]       done
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t           r_state, w_next;
  logic             r_ptr;
  logic [1:0]       r_grant;
  logic [WIDTH-1:0] r_count;
  logic             w_sel;
  logic             w_release;
  assign w_sel     = (req == 2'b11) ? r_ptr : req[1];
  assign w_release = (r_state == COUNT && abort) || r_state == DONE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |req ? COUNT : IDLE;
      COUNT:   w_next = abort ? IDLE : (r_count == '0 ? DONE : COUNT);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_grant <= 2'b00;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |req) begin
        r_grant <= w_sel ? 2'b10 : 2'b01;
        r_count <= w_sel ? load_val1 : load_val0;
      end else if (r_state == COUNT && !abort && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
      // the requester just released loses priority to the other one
      if (w_release) begin
        r_grant <= 2'b00;
        r_ptr   <= r_grant[0];
      end
    end
  end
  assign grant     = r_grant;
  assign busy      = r_state != IDLE;
  assign count_out = r_count;
  assign done      = (r_state == DONE) ? r_grant : 2'b00;
endmodule
